// File: rtl/bg_pe_scheduler.sv
// Two-phase frame sequencer for the background-removal PE array: sum collection, mean, then removal.
// Optional watchdog on the PE wait states is compiled in with `define TIMEOUT_EN.
module bg_pe_scheduler #(
    parameter int NUM_PE         = 4,
    parameter int SUM_W          = 8,
    parameter int LOG2_TOTAL     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error,
    output logic                    Start_Sum,
    output logic                    Start_BgRemoval,
    output logic                    Ack,
    input  logic [NUM_PE-1:0]       sum_done,
    input  logic [NUM_PE-1:0]       bg_done,
    input  logic [SUM_W*NUM_PE-1:0] red_sum_in,
    input  logic [SUM_W*NUM_PE-1:0] green_sum_in,
    input  logic [SUM_W*NUM_PE-1:0] blue_sum_in,
    output logic [7:0]              red_exp,
    output logic [7:0]              green_exp,
    output logic [7:0]              blue_exp
);

    localparam int TOT_W = SUM_W + $clog2(NUM_PE) + 1;

    typedef enum logic [8:0] {
        S_IDLE      = 9'b000000001,
        S_SUM_START = 9'b000000010,
        S_SUM_WAIT  = 9'b000000100,
        S_SUM_ACK   = 9'b000001000,
        S_AVG       = 9'b000010000,
        S_BG_START  = 9'b000100000,
        S_BG_WAIT   = 9'b001000000,
        S_BG_ACK    = 9'b010000000,
        S_FIN       = 9'b100000000
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_PE-1:0]         done_seen_q, done_seen_d;
    logic [SUM_W*NUM_PE-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [7:0]                rexp_q, rexp_d, gexp_q, gexp_d, bexp_q, bexp_d;
    logic [NUM_PE-1:0]         seen_all;
    logic                      all_done;
    logic                      in_wait;
    logic                      wd_expire;
    logic                      abort;

    // Sum of all PE channel sums divided by the pixel count, clamped to one byte.
    function automatic logic [7:0] mean_sat(input logic [SUM_W*NUM_PE-1:0] bus);
        logic [TOT_W-1:0]   total;
        logic [TOT_W+7:0]   shifted;
        total = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            total = total + TOT_W'(bus[k*SUM_W +: SUM_W]);
        end
        shifted = {8'b0, total} >> LOG2_TOTAL;
        return (|shifted[TOT_W+7:8]) ? 8'hFF : shifted[7:0];
    endfunction

    assign in_wait  = (state_q == S_SUM_WAIT) || (state_q == S_BG_WAIT);
    assign seen_all = done_seen_q | ((state_q == S_SUM_WAIT) ? sum_done : bg_done);
    assign all_done = &seen_all;

    // NOTE: the whole register set, sum latches included, is reset so that an
    // abort mid-job leaves no stale data visible on the exp buses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            done_seen_q <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            rexp_q      <= '0;
            gexp_q      <= '0;
            bexp_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            done_seen_q <= done_seen_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            rexp_q      <= rexp_d;
            gexp_q      <= gexp_d;
            bexp_q      <= bexp_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first, so no path infers a latch.
        state_d     = state_q;
        done_seen_d = done_seen_q;
        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
        rexp_d      = rexp_q;
        gexp_d      = gexp_q;
        bexp_d      = bexp_q;
        case (state_q)
            S_IDLE:      if (Start) state_d = S_SUM_START;
            S_SUM_START: begin
                done_seen_d = '0;
                state_d     = S_SUM_WAIT;
            end
            S_SUM_WAIT: begin
                done_seen_d = seen_all;
                if (all_done) begin
                    state_d = S_SUM_ACK;
                    red_d   = red_sum_in;
                    green_d = green_sum_in;
                    blue_d  = blue_sum_in;
                end else if (wd_expire) begin
                    state_d = S_SUM_ACK;
                end
            end
            S_SUM_ACK:   state_d = abort ? S_IDLE : S_AVG;
            S_AVG: begin
                rexp_d  = mean_sat(red_q);
                gexp_d  = mean_sat(green_q);
                bexp_d  = mean_sat(blue_q);
                state_d = S_BG_START;
            end
            S_BG_START: begin
                done_seen_d = '0;
                state_d     = S_BG_WAIT;
            end
            S_BG_WAIT: begin
                done_seen_d = seen_all;
                if (all_done || wd_expire) state_d = S_BG_ACK;
            end
            S_BG_ACK:    state_d = abort ? S_IDLE : S_FIN;
            S_FIN:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

`ifdef TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
    logic            error_q, error_d;
    logic            trip;

    // A wait that completes on the limit cycle still counts as a normal finish.
    assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign trip      = in_wait && !all_done && wd_expire;
    assign abort     = timeout_q;
    assign Error     = error_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        error_d   = error_q | trip;
        if (state_q == S_SUM_START || state_q == S_BG_START) wd_d = '0;
        else if (in_wait && !wd_expire)                      wd_d = wd_q + WD_W'(1);
        if (trip)                                            timeout_d = 1'b1;
        else if (state_q == S_SUM_ACK || state_q == S_BG_ACK) timeout_d = 1'b0;
    end
`else
    assign wd_expire = 1'b0;
    assign abort     = 1'b0;
    assign Error     = 1'b0;
`endif

    assign Busy            = (state_q != S_IDLE);
    assign Done            = (state_q == S_FIN);
    assign Start_Sum       = (state_q == S_SUM_START);
    assign Start_BgRemoval = (state_q == S_BG_START);
    assign Ack             = (state_q == S_SUM_ACK) || (state_q == S_BG_ACK);
    assign red_exp         = rexp_q;
    assign green_exp       = gexp_q;
    assign blue_exp        = bexp_q;

endmodule

// File: tb/tb_bg_pe_scheduler.sv
// Randomised directed bench for bg_pe_scheduler; a second instance with LOG2_TOTAL=0 exercises saturation.
// Define TIMEOUT_EN for both RTL and bench to include the watchdog scenario.
module tb_bg_pe_scheduler;

    localparam int NUM_PE = 4;
    localparam int SUM_W  = 8;
    localparam int TO     = 16;
    localparam int NEVER  = 999;

    logic        Clk = 1'b0;
    logic        Reset, Start;
    logic [3:0]  sum_done, bg_done;
    logic [31:0] red_sum_in, green_sum_in, blue_sum_in;

    logic       Busy, Done, Error, Start_Sum, Start_BgRemoval, Ack;
    logic [7:0] red_exp, green_exp, blue_exp;
    logic       s_busy, s_done, s_error, s_ss, s_sbg, s_ack;
    logic [7:0] s_red, s_green, s_blue;

    int checks   = 0;
    int failures = 0;

    int j_red[4], j_grn[4], j_blu[4], j_sd[4], j_bd[4];
    bit j_pulse, j_abort;
    int j_hold;
    int exp_err;
    int m_r, m_g, m_b, ms_r, ms_g, ms_b;

    bg_pe_scheduler #(.NUM_PE(NUM_PE), .SUM_W(SUM_W), .LOG2_TOTAL(2), .TIMEOUT_CYCLES(TO)) u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Busy(Busy), .Done(Done), .Error(Error),
        .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
        .sum_done(sum_done), .bg_done(bg_done),
        .red_sum_in(red_sum_in), .green_sum_in(green_sum_in), .blue_sum_in(blue_sum_in),
        .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp)
    );

    bg_pe_scheduler #(.NUM_PE(NUM_PE), .SUM_W(SUM_W), .LOG2_TOTAL(0), .TIMEOUT_CYCLES(TO)) u_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Busy(s_busy), .Done(s_done), .Error(s_error),
        .Start_Sum(s_ss), .Start_BgRemoval(s_sbg), .Ack(s_ack),
        .sum_done(sum_done), .bg_done(bg_done),
        .red_sum_in(red_sum_in), .green_sum_in(green_sum_in), .blue_sum_in(blue_sum_in),
        .red_exp(s_red), .green_exp(s_green), .blue_exp(s_blue)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Control vector order: {Busy, Start_Sum, Start_BgRemoval, Ack, Done}.
    task automatic chk_ctrl(input string tag, input logic [4:0] e);
        check(tag, 32'({Busy, Start_Sum, Start_BgRemoval, Ack, Done}), 32'(e));
        check({tag, "_sat"}, 32'({s_busy, s_ss, s_sbg, s_ack, s_done}), 32'(e));
    endtask

    task automatic chk_err(input string tag);
        check(tag, 32'(Error), exp_err);
        check({tag, "_sat"}, 32'(s_error), exp_err);
    endtask

    task automatic chk_exps(input string tag);
        check({tag, "_red"},       32'(red_exp),   m_r);
        check({tag, "_green"},     32'(green_exp), m_g);
        check({tag, "_blue"},      32'(blue_exp),  m_b);
        check({tag, "_sat_red"},   32'(s_red),     ms_r);
        check({tag, "_sat_green"}, 32'(s_green),   ms_g);
        check({tag, "_sat_blue"},  32'(s_blue),    ms_b);
    endtask

    // Reference: mean over all pixels is the total sum divided by 2^lg, clamped to 255.
    function automatic int mean_sat(input int a[4], input int lg);
        int t;
        t = 0;
        foreach (a[i]) t += a[i];
        t = t / (1 << lg);
        return (t > 255) ? 255 : t;
    endfunction

    function automatic logic [3:0] sched(input int d[4], input int k, input bit pulse);
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = pulse ? (d[i] == k) : (d[i] <= k);
        return f;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_sums(input bit real_v);
        for (int k = 0; k < NUM_PE; k++) begin
            red_sum_in[k*8 +: 8]   = real_v ? j_red[k][7:0] : 8'($urandom);
            green_sum_in[k*8 +: 8] = real_v ? j_grn[k][7:0] : 8'($urandom);
            blue_sum_in[k*8 +: 8]  = real_v ? j_blu[k][7:0] : 8'($urandom);
        end
    endtask

    task automatic rand_job();
        for (int i = 0; i < 4; i++) begin
            j_red[i] = $urandom_range(0, 255);
            j_grn[i] = $urandom_range(0, 255);
            j_blu[i] = $urandom_range(0, 255);
            j_sd[i]  = $urandom_range(0, 5);
            j_bd[i]  = $urandom_range(0, 5);
        end
        j_pulse = 1'($urandom);
        j_hold  = 1;
        j_abort = 1'b0;
    endtask

    // One job with cycle-exact expectations; cycle 0 is the cycle Start is first sampled.
    task automatic run_job();
        int  c, d, e;
        bit  to;
        d = 0;
        e = 0;
        for (int i = 0; i < 4; i++) begin
            if (j_sd[i] > d) d = j_sd[i];
            if (j_bd[i] > e) e = j_bd[i];
        end
        to = (e >= TO);
        c = 0;
        Start = 1'b1; sum_done = '0; bg_done = '0; drive_sums(1'b0);
        step(); c++;
        Start = (c < j_hold) || 1'($urandom);
        sum_done = 4'($urandom); bg_done = 4'($urandom); drive_sums(1'b0);
        chk_ctrl("sum_start", 5'b11000);
        step(); c++;
        for (int k = 0; k <= d; k++) begin
            Start = (c < j_hold) || 1'($urandom);
            sum_done = sched(j_sd, k, j_pulse); bg_done = 4'($urandom);
            drive_sums(k == d);
            chk_ctrl("sum_wait", 5'b10000);
            step(); c++;
        end
        Start = (c < j_hold) || 1'($urandom);
        sum_done = 4'($urandom); drive_sums(1'b0);
        chk_ctrl("sum_ack", 5'b10010);
        step(); c++;
        m_r  = mean_sat(j_red, 2); m_g  = mean_sat(j_grn, 2); m_b  = mean_sat(j_blu, 2);
        ms_r = mean_sat(j_red, 0); ms_g = mean_sat(j_grn, 0); ms_b = mean_sat(j_blu, 0);
        Start = (c < j_hold) || 1'($urandom);
        chk_ctrl("avg", 5'b10000);
        step(); c++;
        Start = (c < j_hold) || 1'($urandom);
        bg_done = 4'($urandom);
        chk_ctrl("bg_start", 5'b10100);
        chk_exps("exp");
        step(); c++;
        for (int k = 0; k <= (to ? TO - 1 : e); k++) begin
            Start = (c < j_hold) || 1'($urandom);
            bg_done = sched(j_bd, k, j_pulse); sum_done = 4'($urandom);
            if (j_abort && k == 1) begin
                #2 Reset = 1'b1;
                #1;
                m_r = 0; m_g = 0; m_b = 0; ms_r = 0; ms_g = 0; ms_b = 0;
                exp_err = 0;
                chk_ctrl("rst_mid", 5'b00000);
                chk_exps("rst_mid");
                chk_err("rst_mid_err");
                Start = 1'b0;
                repeat (2) step();
                Reset = 1'b0;
                step();
                return;
            end
            chk_ctrl("bg_wait", 5'b10000);
            step(); c++;
        end
        if (to) begin
            exp_err = 1;
            Start = 1'b0;
            chk_ctrl("to_ack", 5'b10010);
            chk_err("to_err");
            step();
            for (int k = 0; k < 4; k++) begin
                chk_ctrl("to_idle", 5'b00000);
                step();
            end
            return;
        end
        Start = (c < j_hold) || 1'($urandom);
        chk_ctrl("bg_ack", 5'b10010);
        step(); c++;
        Start = 1'b0; sum_done = '0; bg_done = '0;
        chk_ctrl("fin", 5'b10001);
        step();
        chk_ctrl("idle", 5'b00000);
        chk_err("idle_err");
        chk_exps("hold");
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; sum_done = '0; bg_done = '0;
        red_sum_in = '0; green_sum_in = '0; blue_sum_in = '0;
        exp_err = 0;
        m_r = 0; m_g = 0; m_b = 0; ms_r = 0; ms_g = 0; ms_b = 0;
        repeat (2) step();
        chk_ctrl("reset", 5'b00000);
        chk_err("reset_err");
        chk_exps("reset");
        Reset = 1'b0;
        step();

        // Idle: done flags and bus noise without Start must not start anything.
        for (int k = 0; k < 3; k++) begin
            sum_done = 4'($urandom); bg_done = 4'($urandom); drive_sums(1'b0);
            step();
            chk_ctrl("idle_noise", 5'b00000);
        end

        // Reference mean: expect 25/4/0, and 100/16/3 on the unshifted instance.
        j_red = '{10, 20, 30, 40}; j_grn = '{4, 4, 4, 4}; j_blu = '{0, 0, 0, 3};
        j_sd = '{0, 0, 0, 0}; j_bd = '{0, 0, 0, 0};
        j_pulse = 1'b0; j_hold = 1; j_abort = 1'b0;
        run_job();

        // Saturation: 1020 clamps to 255 on the LOG2_TOTAL=0 instance.
        j_red = '{255, 255, 255, 255}; j_grn = '{255, 0, 0, 1}; j_blu = '{128, 128, 0, 0};
        run_job();

        // Staggered single-cycle pulses PE3, PE0, PE2, PE1.
        j_sd = '{1, 3, 2, 0}; j_bd = '{2, 0, 3, 1}; j_pulse = 1'b1;
        run_job();

        // Start held for 20 cycles across a long job.
        rand_job();
        j_sd = '{7, 2, 5, 0}; j_bd = '{1, 7, 3, 6}; j_hold = 20;
        run_job();

        // Reset during BG_WAIT, then a normal job.
        rand_job();
        j_bd = '{5, 5, 5, 5}; j_abort = 1'b1;
        run_job();
        rand_job();
        run_job();

        for (int n = 0; n < 25; n++) begin
            rand_job();
            run_job();
        end

`ifdef TIMEOUT_EN
        rand_job();
        j_bd = '{0, 1, NEVER, 2};
        run_job();
        rand_job();
        run_job();
        Reset = 1'b1;
        #1;
        exp_err = 0;
        chk_err("err_clear");
        Reset = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bg_pe_scheduler.md
Name: bg_pe_scheduler

Overview:
Sequencing controller for an array of NUM_PE background-removal processing elements.
- Runs one frame job in two phases:
  - Phase 1 broadcasts Start_Sum and collects per-PE RGB sums. It then computes the expected background colour as the mean over all pixels.
  - Phase 2 broadcasts Start_BgRemoval with that colour driven on the exp buses.
- Handles the Ack handshake that returns every PE to its idle state.
- Sits between the frame-level host and the PE array.

Parameters:
NUM_PE, 4, number of processing elements controlled (1..16)
SUM_W, 8, width of each per-PE channel sum bus
LOG2_TOTAL, 2, log2 of total pixels across all PEs; the mean divisor is 2^LOG2_TOTAL
TIMEOUT_CYCLES, 1024, watchdog limit in cycles per wait phase (used only with TIMEOUT_EN)

Ports:
Clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  host job request, sampled in IDLE only
Busy  out  1  high whenever state != IDLE
Done  out  1  one-cycle pulse at job completion
Error  out  1  sticky watchdog flag; tied 0 without TIMEOUT_EN
Start_Sum  out  1  broadcast to all PEs, one-cycle pulse
Start_BgRemoval  out  1  broadcast to all PEs, one-cycle pulse
Ack  out  1  broadcast to all PEs, one-cycle pulse
sum_done  in  NUM_PE  per-PE Qsd
bg_done  in  NUM_PE  per-PE Qbgd
red_sum_in  in  SUM_W*NUM_PE  packed per-PE red sums; PE k occupies [k*SUM_W +: SUM_W]
green_sum_in  in  SUM_W*NUM_PE  packed green sums, same packing
blue_sum_in  in  SUM_W*NUM_PE  packed blue sums, same packing
red_exp  out  8  registered expected red, driven to all PEs
green_exp  out  8  registered expected green
blue_exp  out  8  registered expected blue

Behaviour:
- Reset (async, any state, mid-job included): state=IDLE; all outputs 0; done_seen=0; watchdog=0; Error=0.
- State is one-hot: IDLE, SUM_START, SUM_WAIT, SUM_ACK, AVG, BG_START, BG_WAIT, BG_ACK, FIN.
- IDLE: Start=1 -> SUM_START. Start is ignored in every other state; it is not queued.
- SUM_START: Start_Sum=1 for this cycle; clear done_seen -> SUM_WAIT.
- SUM_WAIT:
  - done_seen |= sum_done each cycle. The flags are sticky, so PEs may finish in any order, or pulse their done flag instead of holding it.
  - When (done_seen | sum_done) is all ones -> SUM_ACK. In the same cycle, latch all three sum buses into internal registers.
- SUM_ACK: Ack=1 for one cycle -> AVG.
- AVG:
  - Per channel: total = sum of NUM_PE latched sums, width SUM_W+clog2(NUM_PE)+1, no overflow loss.
  - exp = total >> LOG2_TOTAL, saturated to 255.
  - Register red/green/blue_exp -> BG_START.
  - exp outputs hold until the next AVG or reset.
- BG_START: Start_BgRemoval=1 for one cycle; clear done_seen -> BG_WAIT.
- BG_WAIT: same as SUM_WAIT, using bg_done -> BG_ACK. No data latch.
- BG_ACK: Ack=1 for one cycle -> FIN.
- FIN: Done=1 for one cycle -> IDLE. Busy falls in the cycle Done is high+1.
- Latency with all PEs done immediately: Start sampled at cycle 0; Start_Sum high at cycle 1; Start_BgRemoval high at cycle 5 earliest; Done high at cycle 8.
- Mutual exclusion: Start_Sum, Start_BgRemoval and Ack are never high in the same cycle.
- Done flags are sampled only in the WAIT states. Flags asserted in any other state are ignored.

Optional Feature:
TIMEOUT_EN
- With the macro:
  - A watchdog counter clears on entry to SUM_WAIT and BG_WAIT and increments each cycle spent in those states.
  - On reaching TIMEOUT_CYCLES: set Error=1 (sticky until Reset), pulse Ack for one cycle to release the PEs, then go to IDLE. Done is not pulsed.
  - Error clears only on Reset.
- Without the macro: no counter exists; WAIT states wait indefinitely; Error is constant 0.

Test Plan:
- NUM_PE=4, LOG2_TOTAL=2; red sums 10,20,30,40; green 4,4,4,4; blue 0,0,0,3; all PEs done immediately -> red_exp=25, green_exp=4, blue_exp=0. Start_BgRemoval at cycle 5; Done at cycle 8.
- Saturation: LOG2_TOTAL=0, all red sums 255 -> red_exp=255, not 1020 truncated.
- Staggered done: sum_done bits pulse one at a time (PE3, PE0, PE2, PE1) on separate cycles -> single Ack exactly one cycle after the last bit; no early Ack.
- Start held high for 20 cycles -> exactly one Start_Sum pulse and one Done pulse; Busy stays high throughout.
- Reset asserted during BG_WAIT -> same-cycle Busy=0, exp=0, Ack=0. A new Start afterwards runs a full job normally.
- TIMEOUT_EN, TIMEOUT_CYCLES=16, one bg_done bit never asserted -> Error=1 and one Ack pulse 16 cycles after BG_WAIT entry; then IDLE with no Done pulse.
